// File: rtl/beta_seq_ctl_if.sv
// Opcode/status inputs and datapath control bundle of the Beta sequencer.
// master = sequencer side, slave = instruction register / datapath side.
interface beta_seq_ctl_if;
  logic [5:0] op;
  logic       z;
  logic       irq;
  logic       sup;
  logic       mem_ready;
  logic [5:0] alufn;
  logic [2:0] pcsel;
  logic [1:0] wdsel;
  logic       asel;
  logic       bsel;
  logic       moe;
  logic       mwr;
  logic       ra2sel;
  logic       wasel;
  logic       werf;
  logic       pc_en;
  logic       busy;

  modport master (
    input  op, z, irq, sup, mem_ready,
    output alufn, pcsel, wdsel, asel, bsel, moe, mwr, ra2sel, wasel, werf, pc_en, busy
  );

  modport slave (
    output op, z, irq, sup, mem_ready,
    input  alufn, pcsel, wdsel, asel, bsel, moe, mwr, ra2sel, wasel, werf, pc_en, busy
  );
endinterface

// File: rtl/beta_seq_ctl.sv
// Beta control unit: opcode decode, multi-cycle MUL/DIV, memory wait states, IRQ trap.
// Controls are combinational; MUL/DIV stall pc_en for N-1 cycles, memory ops stall until mem_ready.
module beta_seq_ctl #(
  parameter int MUL_CYCLES  = 4,
  parameter int DIV_CYCLES  = 16,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic           clk,
  input logic           reset_n,
  beta_seq_ctl_if.master bus
);
  localparam int MAX_N = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW    = (MAX_N > 2) ? $clog2(MAX_N - 1) : 1;
  localparam logic [CW-1:0] MUL_INIT = CW'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
  localparam logic [CW-1:0] DIV_INIT = CW'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);

  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [5:0] OP_LDR = 6'h1F;

  typedef enum logic {RUN, MD_BUSY} state_t;

  typedef struct packed {
    logic [5:0] alufn;
    logic [2:0] pcsel;
    logic [1:0] wdsel;
    logic       asel;
    logic       bsel;
    logic       moe;
    logic       mwr;
    logic       ra2sel;
    logic       wasel;
    logic       werf;
    logic       pc_en;
    logic       busy;
  } ctl_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall_q, stall_d;
  logic          irq_s1, irq_s2, irq_pend;
  logic          trap, werf_ok, pc_en, busy;
  logic          is_alu, is_mul, is_md, is_mem, md_multi;
  ctl_t          dec, ctl;

  assign is_alu   = bus.op[5] && (bus.op[3:0] != 4'h7) && (bus.op[3:0] != 4'hF);
  assign is_mul   = bus.op[5] && (bus.op[3:0] == 4'h2);
  assign is_md    = bus.op[5] && (bus.op[3:1] == 3'b001);
  assign is_mem   = (bus.op == OP_LD) || (bus.op == OP_ST) || (bus.op == OP_LDR);
  assign md_multi = is_mul ? (MUL_CYCLES > 1) : (DIV_CYCLES > 1);

  always_comb begin
    dec = '0;
    case (bus.op)
      OP_LD:  begin dec.alufn = 6'b010000; dec.bsel = 1'b1; dec.moe = 1'b1; dec.wdsel = 2'd2; dec.werf = 1'b1; end
      OP_ST:  begin dec.alufn = 6'b010000; dec.bsel = 1'b1; dec.mwr = 1'b1; dec.ra2sel = 1'b1; end
      OP_JMP: begin dec.pcsel = 3'd2; dec.werf = 1'b1; end
      OP_BEQ: dec.pcsel = {2'b00, bus.z};
      OP_BNE: dec.pcsel = {2'b00, ~bus.z};
      OP_LDR: begin dec.alufn = 6'b100000; dec.asel = 1'b1; dec.moe = 1'b1; dec.wdsel = 2'd2; dec.werf = 1'b1; end
      default: begin
        if (is_alu) begin
          dec.alufn = {2'b01, bus.op[3:0]};
          dec.bsel  = bus.op[4];
          dec.wdsel = 2'd1;
          dec.werf  = 1'b1;
        end else begin
          dec.pcsel = 3'd3;
          dec.wasel = 1'b1;
          dec.werf  = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = 1'b0;
    trap    = 1'b0;
    werf_ok = 1'b1;
    pc_en   = 1'b1;
    busy    = 1'b0;
    case (state_q)
      RUN: begin
        // A boundary is any RUN cycle not continuing a memory stall.
        if (!stall_q && irq_pend && !bus.sup) begin
          trap = 1'b1;
        end else if (is_md && md_multi) begin
          werf_ok = 1'b0;
          pc_en   = 1'b0;
          busy    = 1'b1;
          state_d = MD_BUSY;
          cnt_d   = is_mul ? MUL_INIT : DIV_INIT;
        end else if (is_mem && MEM_WAIT_EN && !bus.mem_ready) begin
          werf_ok = 1'b0;
          pc_en   = 1'b0;
          stall_d = 1'b1;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          werf_ok = 1'b0;
          pc_en   = 1'b0;
          busy    = 1'b1;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ctl       = dec;
    ctl.werf  = dec.werf & werf_ok;
    ctl.pc_en = pc_en;
    ctl.busy  = busy;
    if (trap) begin
      ctl       = '0;
      ctl.pcsel = 3'd4;
      ctl.wasel = 1'b1;
      ctl.werf  = 1'b1;
      ctl.pc_en = 1'b1;
    end
    if (!reset_n) ctl = '0;
  end

  assign bus.alufn  = ctl.alufn;
  assign bus.pcsel  = ctl.pcsel;
  assign bus.wdsel  = ctl.wdsel;
  assign bus.asel   = ctl.asel;
  assign bus.bsel   = ctl.bsel;
  assign bus.moe    = ctl.moe;
  assign bus.mwr    = ctl.mwr;
  assign bus.ra2sel = ctl.ra2sel;
  assign bus.wasel  = ctl.wasel;
  assign bus.werf   = ctl.werf;
  assign bus.pc_en  = ctl.pc_en;
  assign bus.busy   = ctl.busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      stall_q  <= 1'b0;
      irq_s1   <= 1'b0;
      irq_s2   <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      irq_s1   <= bus.irq;
      irq_s2   <= irq_s1;
      irq_pend <= irq_s2 | (irq_pend & ~trap);
    end
  end
endmodule

// File: tb/tb_beta_seq_ctl.sv
// Bench for beta_seq_ctl: directed scenarios with literal expectations, then random stimulus
// checked every cycle against a transaction-level model of the control rules.
module tb_beta_seq_ctl;
  localparam int MULN = 4;
  localparam int DIVN = 16;
  localparam logic [5:0] ADD = 6'h20, MUL = 6'h22, DIV = 6'h23;
  localparam logic [5:0] LD = 6'h18, ST = 6'h19, BEQ = 6'h1C, BNE = 6'h1D;

  typedef struct packed {
    logic [5:0] alufn;
    logic [2:0] pcsel;
    logic [1:0] wdsel;
    logic       asel;
    logic       bsel;
    logic       moe;
    logic       mwr;
    logic       ra2sel;
    logic       wasel;
    logic       werf;
    logic       pc_en;
    logic       busy;
  } ctl_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  beta_seq_ctl_if bus();

  beta_seq_ctl #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  ctl_t last;
  bit   hold = 1'b0;

  // Model state: remaining busy cycles of a MUL/DIV, memory stall flag, irq delay line.
  int md_left = 0;
  bit m_stall = 1'b0, m_s1 = 1'b0, m_s2 = 1'b0, m_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_alu(logic [5:0] o);
    return o[5] && (o[3:0] <= 4'hE) && (o[3:0] != 4'h7);
  endfunction

  function automatic bit is_mem(logic [5:0] o);
    return (o == 6'h18) || (o == 6'h19) || (o == 6'h1F);
  endfunction

  function automatic int md_cycles(logic [5:0] o);
    if (o[5] && o[3:0] == 4'h2) return MULN;
    if (o[5] && o[3:0] == 4'h3) return DIVN;
    return 0;
  endfunction

  function automatic ctl_t dec(logic [5:0] o, logic zz);
    ctl_t d;
    d = '0;
    d.pc_en = 1'b1;
    case (o)
      6'h18: begin d.alufn = 6'b010000; d.bsel = 1; d.moe = 1; d.wdsel = 2; d.werf = 1; end
      6'h19: begin d.alufn = 6'b010000; d.bsel = 1; d.mwr = 1; d.ra2sel = 1; end
      6'h1B: begin d.pcsel = 2; d.werf = 1; end
      6'h1C: d.pcsel = zz ? 3'd1 : 3'd0;
      6'h1D: d.pcsel = zz ? 3'd0 : 3'd1;
      6'h1F: begin d.alufn = 6'b100000; d.asel = 1; d.moe = 1; d.wdsel = 2; d.werf = 1; end
      default:
        if (is_alu(o)) begin
          d.alufn = 6'h10 + {2'b00, o[3:0]};
          d.bsel  = o[4];
          d.wdsel = 1;
          d.werf  = 1;
        end else begin
          d.pcsel = 3; d.wasel = 1; d.werf = 1;
        end
    endcase
    return d;
  endfunction

  function automatic ctl_t expect_ctl(logic [5:0] o, logic zz, logic sp, logic mr, logic rn,
                                      output bit tr);
    ctl_t e;
    tr = 1'b0;
    e = dec(o, zz);
    if (!rn) return '0;
    if (md_left > 0) begin
      if (md_left > 1) begin e.werf = 0; e.pc_en = 0; e.busy = 1; end
    end else if (!m_stall && m_pend && !sp) begin
      tr = 1'b1;
      e = '0; e.pcsel = 4; e.wasel = 1; e.werf = 1; e.pc_en = 1;
    end else if (md_cycles(o) > 1) begin
      e.werf = 0; e.pc_en = 0; e.busy = 1;
    end else if (is_mem(o) && !mr) begin
      e.werf = 0; e.pc_en = 0;
    end
    return e;
  endfunction

  task automatic step(input logic [5:0] o, input logic zz, input logic ii, input logic sp,
                      input logic mr, input logic rn);
    ctl_t e, a;
    bit   tr, nstall, npend;
    @(negedge clk);
    reset_n = rn; bus.op = o; bus.z = zz; bus.irq = ii; bus.sup = sp; bus.mem_ready = mr;
    #2;
    e = expect_ctl(o, zz, sp, mr, rn, tr);
    a = {bus.alufn, bus.pcsel, bus.wdsel, bus.asel, bus.bsel, bus.moe, bus.mwr,
         bus.ra2sel, bus.wasel, bus.werf, bus.pc_en, bus.busy};
    cyc++;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL ctl cycle %0d op=%0h: got %h expected %h", cyc, o, a, e);
    end
    last = a;
    hold = rn && !e.pc_en;
    @(posedge clk);
    if (!rn) begin
      md_left = 0; m_stall = 0; m_s1 = 0; m_s2 = 0; m_pend = 0;
    end else begin
      nstall = (md_left == 0) && !tr && is_mem(o) && !mr;
      npend  = m_s2 | (m_pend & !tr);
      m_s2 = m_s1; m_s1 = ii; m_pend = npend;
      if (md_left > 0) md_left--;
      else if (!tr && md_cycles(o) > 1) md_left = md_cycles(o) - 1;
      m_stall = nstall;
    end
  endtask

  initial begin
    int n, cnt;
    bit done;
    logic [5:0] o;
    logic zz, ii, sp, mr, rn;
    bus.op = ADD; bus.z = 0; bus.irq = 0; bus.sup = 0; bus.mem_ready = 1;

    // Reset with ADD presented, then first decode cycle.
    step(ADD, 0, 0, 0, 1, 0);
    chk("rst_outputs", {last.pc_en, last.werf, last.mwr, last.busy, last.moe}, 5'b00000);
    step(ADD, 0, 0, 0, 1, 1);
    chk("add_after_rst", {last.alufn, last.wdsel, last.werf, last.pc_en}, {6'b010000, 2'd1, 2'b11});

    // MUL occupies four cycles.
    n = 0;
    for (int k = 0; k < 3; k++) begin
      step(MUL, 0, 0, 0, 1, 1);
      if (last.busy && !last.pc_en && !last.werf) n++;
    end
    chk("mul_busy_cycles", n, 3);
    step(MUL, 0, 0, 0, 1, 1);
    chk("mul_write", {last.werf, last.pc_en, last.busy}, 3'b110);

    // DIV with an irq pulse part-way through; trap lands on the next instruction.
    n = 0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      step(DIV, 0, (k == 2 || k == 3), 0, 1, 1);
      n++;
      if (last.pc_en) done = 1;
    end
    chk("div_latency", n, 16);
    chk("div_write", last.werf, 1);
    step(ADD, 0, 0, 0, 1, 1);
    chk("irq_trap", {last.pcsel, last.wasel, last.werf, last.pc_en}, {3'd4, 3'b111});
    step(ADD, 0, 0, 0, 1, 1);
    chk("irq_cleared", {last.pcsel, last.werf}, {3'd0, 1'b1});

    // Memory wait states.
    n = 0;
    for (int k = 0; k < 3; k++) begin
      step(LD, 0, 0, 0, 0, 1);
      if (!last.pc_en && !last.werf && last.moe) n++;
    end
    chk("ld_stall_cycles", n, 3);
    step(LD, 0, 0, 0, 1, 1);
    chk("ld_done", {last.werf, last.wdsel, last.pc_en}, 4'b1101);
    n = 0;
    for (int k = 0; k < 3; k++) begin
      step(ST, 0, 0, 0, 0, 1);
      if (!last.pc_en && !last.werf && last.mwr) n++;
    end
    chk("st_stall_cycles", n, 3);
    step(ST, 0, 0, 0, 1, 1);
    chk("st_done", {last.mwr, last.werf, last.pc_en}, 3'b101);

    // Branches and illegal opcode.
    step(BEQ, 1, 0, 0, 1, 1);
    chk("beq_taken", last.pcsel, 1);
    step(BNE, 1, 0, 0, 1, 1);
    chk("bne_not_taken", last.pcsel, 0);
    step(6'h27, 0, 0, 0, 1, 1);
    chk("illop", {last.pcsel, last.wasel, last.werf}, {3'd3, 2'b11});

    // Supervisor mode masks the trap until it drops.
    step(ADD, 0, 1, 1, 1, 1);
    step(ADD, 0, 1, 1, 1, 1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step(ADD, 0, 0, 1, 1, 1);
      if (last.pcsel == 3'd4) cnt++;
    end
    chk("sup_no_trap", cnt, 0);
    step(ADD, 0, 0, 0, 1, 1);
    chk("sup_released_trap", {last.pcsel, last.wasel, last.werf}, {3'd4, 2'b11});
    step(ADD, 0, 0, 0, 1, 1);

    // Reset in the middle of a MUL abandons it.
    step(MUL, 0, 0, 0, 1, 1);
    step(MUL, 0, 0, 0, 1, 0);
    chk("mul_rst_no_write", {last.werf, last.busy, last.pc_en}, 3'b000);
    step(ADD, 0, 0, 0, 1, 1);
    chk("mul_rst_recover", {last.busy, last.werf, last.pc_en, last.alufn}, {3'b011, 6'b010000});

    // Random traffic against the model.
    o = ADD;
    for (int i = 0; i < 4000; i++) begin
      if (!hold) begin
        case ($urandom_range(0, 9))
          0: o = LD;
          1: o = ST;
          2: o = 6'h1F;
          3: o = $urandom_range(0, 1) ? MUL : 6'h32;
          4: o = $urandom_range(0, 1) ? DIV : 6'h33;
          5: o = $urandom_range(0, 1) ? BEQ : BNE;
          6: o = 6'h1B;
          7, 8: o = 6'(6'h20 + $urandom_range(0, 31));
          default: o = 6'($urandom_range(0, 63));
        endcase
      end
      zz = 1'($urandom_range(0, 1));
      ii = ($urandom_range(0, 29) == 0);
      sp = ($urandom_range(0, 3) == 0);
      mr = ($urandom_range(0, 2) != 0);
      rn = ($urandom_range(0, 399) != 0);
      step(o, zz, ii, sp, mr, rn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
